// File: rtl/mem_port_arbiter_if.sv
// Handshake and bus signals shared between fetch, execute, memory and the port arbiter.
interface mem_port_arbiter_if;
  logic        fetch_valid_in;
  logic [31:0] fetch_addr_in;
  logic        fetch_ready_out;
  logic        fetch_rvalid_out;
  logic [31:0] fetch_rdata_out;
  logic        data_valid_in;
  logic        data_write_in;
  logic [31:0] data_addr_in;
  logic [31:0] data_wdata_in;
  logic [7:0]  data_mask_in;
  logic        data_ready_out;
  logic        data_rvalid_out;
  logic [31:0] data_rdata_out;
  logic        mem_valid_out;
  logic        mem_write_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [7:0]  mem_mask_out;
  logic        mem_ready_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic        err_spurious_out;

  modport slave (
    input  fetch_valid_in, fetch_addr_in,
    output fetch_ready_out, fetch_rvalid_out, fetch_rdata_out,
    input  data_valid_in, data_write_in, data_addr_in, data_wdata_in, data_mask_in,
    output data_ready_out, data_rvalid_out, data_rdata_out,
    output mem_valid_out, mem_write_out, mem_addr_out, mem_wdata_out, mem_mask_out,
    input  mem_ready_in, mem_rvalid_in, mem_rdata_in,
    output err_spurious_out
  );

  modport master (
    output fetch_valid_in, fetch_addr_in,
    input  fetch_ready_out, fetch_rvalid_out, fetch_rdata_out,
    output data_valid_in, data_write_in, data_addr_in, data_wdata_in, data_mask_in,
    input  data_ready_out, data_rvalid_out, data_rdata_out,
    input  mem_valid_out, mem_write_out, mem_addr_out, mem_wdata_out, mem_mask_out,
    output mem_ready_in, mem_rvalid_in, mem_rdata_in,
    input  err_spurious_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch reads and data loads/stores; fixed data priority
// with a fetch starvation guard, and an in-order tag FIFO routing read responses back.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic {REQ_FETCH = 1'b0, REQ_DATA = 1'b1} req_id_e;

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    req_id_e       tag_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;

    logic    fetch_wins, data_wins, is_read, issue_ok;
    logic    fetch_acc, data_acc, push, pop;
    req_id_e push_id, head_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_q[wr_ptr_q] <= push_id;
    end

    always_comb begin
        fetch_wins = 1'b0;
        data_wins  = 1'b0;
        is_read    = 1'b0;
        issue_ok   = 1'b0;
        fetch_acc  = 1'b0;
        data_acc   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        push_id    = REQ_FETCH;
        head_id    = tag_q[rd_ptr_q];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        err_d      = err_q;

        bus.mem_valid_out    = 1'b0;
        bus.mem_write_out    = 1'b0;
        bus.mem_addr_out     = bus.data_addr_in;
        bus.mem_wdata_out    = '0;
        bus.mem_mask_out     = '0;
        bus.fetch_ready_out  = 1'b0;
        bus.data_ready_out   = 1'b0;
        bus.fetch_rvalid_out = 1'b0;
        bus.data_rvalid_out  = 1'b0;
        bus.fetch_rdata_out  = bus.mem_rdata_in;
        bus.data_rdata_out   = bus.mem_rdata_in;
        bus.err_spurious_out = err_q;

        if (!reset) begin
            fetch_wins = bus.fetch_valid_in && (!bus.data_valid_in || starve_q >= STARVE_MAX);
            data_wins  = bus.data_valid_in && !fetch_wins;
            is_read    = fetch_wins || !bus.data_write_in;
            // Slot check uses the registered count only: a same-cycle pop frees nothing yet.
            issue_ok   = !is_read || (count_q < MAX_CNT);
            fetch_acc  = fetch_wins && bus.mem_ready_in && issue_ok;
            data_acc   = data_wins && bus.mem_ready_in && issue_ok;

            bus.mem_valid_out   = fetch_wins || data_wins;
            bus.fetch_ready_out = fetch_acc;
            bus.data_ready_out  = data_acc;
            if (fetch_wins) begin
                bus.mem_addr_out = bus.fetch_addr_in;
            end else begin
                bus.mem_write_out = bus.data_write_in;
                bus.mem_wdata_out = bus.data_wdata_in;
                bus.mem_mask_out  = bus.data_mask_in;
            end

            push    = (fetch_acc || data_acc) && is_read;
            push_id = fetch_acc ? REQ_FETCH : REQ_DATA;
            pop     = bus.mem_rvalid_in && (count_q != '0);
            bus.fetch_rvalid_out = pop && (head_id == REQ_FETCH);
            bus.data_rvalid_out  = pop && (head_id == REQ_DATA);
            if (bus.mem_rvalid_in && count_q == '0) err_d = 1'b1;

            if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;

            if (!bus.fetch_valid_in || fetch_acc) starve_d = '0;
            else if (starve_q < STARVE_MAX)      starve_d = starve_q + 1'b1;
        end
    end

endmodule
